// File: rtl/alarm_clock_controller.sv
// Timekeeping and alarm sequencer: 12-hour time and alarm registers, alarm FSM
// (off/armed/ringing/snoozed) and the gated square-wave buzzer output.
module alarm_clock_controller #(
  parameter int ALARM_STEP   = 10,
  parameter int SNOOZE_SEC   = 300,
  parameter int RING_TIMEOUT = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_tone,
  input  logic       sec_adj,
  input  logic       min_adj,
  input  logic       hrs_adj,
  input  logic       al_adj,
  input  logic       al_toggle,
  input  logic       snooze,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [3:0] hours,
  output logic [5:0] al_minutes,
  output logic [3:0] al_hours,
  output logic       al_on,
  output logic       ringing,
  output logic       buzzer_out
);

  localparam int RW = $clog2(RING_TIMEOUT + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SEC);
  localparam logic [6:0]    AL_STEP   = 7'(ALARM_STEP);

  typedef enum logic [1:0] {S_OFF, S_ARMED, S_RINGING, S_SNOOZED} state_t;

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_sec, r_min, r_al_min;
  logic [3:0]    r_hrs, r_al_hrs;
  logic [RW-1:0] r_ring_cnt, w_ring_nxt;
  logic [SW-1:0] r_snz_cnt, w_snz_nxt;
  logic          r_beep, w_beep_nxt;
  logic          r_tone, r_buzzer;
  logic          w_sec_carry, w_min_carry, w_match;
  logic [6:0]    w_al_sum;

  // Carries come only from the 1 Hz chain; adjust-driven wraps stay local.
  assign w_sec_carry = tick_1hz & (r_sec == 6'd59);
  assign w_min_carry = w_sec_carry & (r_min == 6'd59);
  assign w_al_sum    = {1'b0, r_al_min} + AL_STEP;
  assign w_match     = (r_hrs == r_al_hrs) & (r_min == r_al_min) & (r_sec == 6'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec    <= 6'd0;
      r_min    <= 6'd0;
      r_hrs    <= 4'd0;
      r_al_min <= 6'd0;
      r_al_hrs <= 4'd0;
    end else begin
      if (tick_1hz | sec_adj)
        r_sec <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
      if (w_sec_carry | min_adj)
        r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
      if (w_min_carry | hrs_adj)
        r_hrs <= (r_hrs == 4'd11) ? 4'd0 : r_hrs + 4'd1;
      if (al_adj) begin
        if (w_al_sum >= 7'd60) begin
          r_al_min <= 6'(w_al_sum - 7'd60);
          r_al_hrs <= (r_al_hrs == 4'd11) ? 4'd0 : r_al_hrs + 4'd1;
        end else begin
          r_al_min <= w_al_sum[5:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_OFF;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_beep     <= 1'b0;
      r_tone     <= 1'b0;
      r_buzzer   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_nxt;
      r_snz_cnt  <= w_snz_nxt;
      r_beep     <= w_beep_nxt;
      r_tone     <= r_tone ^ tick_tone;
      r_buzzer   <= (r_state == S_RINGING) & r_beep & r_tone;
    end
  end

  // Priority inside each state: al_toggle, then snooze, then match/tick.
  always_comb begin
    w_state_nxt = r_state;
    w_ring_nxt  = r_ring_cnt;
    w_snz_nxt   = r_snz_cnt;
    w_beep_nxt  = r_beep;
    case (r_state)
      S_OFF: begin
        if (al_toggle) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (al_toggle) begin
          w_state_nxt = S_OFF;
        end else if (w_match) begin
          w_state_nxt = S_RINGING;
          w_ring_nxt  = '0;
          w_beep_nxt  = 1'b1;
        end
      end
      S_RINGING: begin
        if (al_toggle) begin
          w_state_nxt = S_OFF;
        end else if (snooze) begin
          w_state_nxt = S_SNOOZED;
          w_snz_nxt   = SNZ_LOAD;
        end else if (tick_1hz) begin
          if (r_ring_cnt == RING_LAST) begin
            w_state_nxt = S_ARMED;
          end else begin
            w_ring_nxt = r_ring_cnt + RW'(1);
            w_beep_nxt = ~r_beep;
          end
        end
      end
      S_SNOOZED: begin
        if (al_toggle) begin
          w_state_nxt = S_OFF;
        end else if (tick_1hz) begin
          if (r_snz_cnt == SW'(1)) begin
            w_state_nxt = S_RINGING;
            w_ring_nxt  = '0;
            w_beep_nxt  = 1'b1;
          end else begin
            w_snz_nxt = r_snz_cnt - SW'(1);
          end
        end
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  assign seconds    = r_sec;
  assign minutes    = r_min;
  assign hours      = r_hrs;
  assign al_minutes = r_al_min;
  assign al_hours   = r_al_hrs;
  assign al_on      = (r_state != S_OFF);
  assign ringing    = (r_state == S_RINGING);
  assign buzzer_out = r_buzzer;

endmodule

// File: tb/tb_alarm_clock_controller.sv
// Bench for alarm_clock_controller: vector table, directed alarm sequences and
// randomized traffic, all compared against an arithmetic reference model.
module tb_alarm_clock_controller;

  localparam int STEP = 10;
  localparam int SN   = 4;
  localparam int RT   = 6;
  localparam int OFF = 0, ARM = 1, RING = 2, SNZ = 3;

  logic clk = 1'b0, reset = 1'b1;
  logic tick_1hz = 1'b0, tick_tone = 1'b0, sec_adj = 1'b0, min_adj = 1'b0;
  logic hrs_adj = 1'b0, al_adj = 1'b0, al_toggle = 1'b0, snooze = 1'b0;
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic al_on, ringing, buzzer_out;

  int total = 0, bad = 0;

  // Reference model: time as fields, alarm as minutes-of-half-day,
  // ring progress as elapsed seconds (beep on even seconds).
  int ms = 0, mm = 0, mh = 0, mal = 0, mst = OFF, mring = 0, msnz = 0;
  bit mtone = 0, mbuz = 0;

  typedef struct {
    bit sa, ma, ha, aa, at, tk;
    int es, em, eh, eam, eah;
    bit eon;
  } vec_t;
  vec_t vecs[9];

  alarm_clock_controller #(.ALARM_STEP(STEP), .SNOOZE_SEC(SN), .RING_TIMEOUT(RT)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .tick_tone(tick_tone),
    .sec_adj(sec_adj), .min_adj(min_adj), .hrs_adj(hrs_adj), .al_adj(al_adj),
    .al_toggle(al_toggle), .snooze(snooze), .seconds(seconds), .minutes(minutes),
    .hours(hours), .al_minutes(al_minutes), .al_hours(al_hours), .al_on(al_on),
    .ringing(ringing), .buzzer_out(buzzer_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int ns, nm, nh, nst, nring, nsnz;
    bit c1, c2, match;
    if (reset) begin
      ms = 0; mm = 0; mh = 0; mal = 0; mst = OFF; mring = 0; msnz = 0;
      mtone = 0; mbuz = 0;
      return;
    end
    c1 = tick_1hz && (ms == 59);
    c2 = c1 && (mm == 59);
    ns = (tick_1hz || sec_adj) ? (ms + 1) % 60 : ms;
    nm = (c1 || min_adj) ? (mm + 1) % 60 : mm;
    nh = (c2 || hrs_adj) ? (mh + 1) % 12 : mh;
    match = ((mh * 60 + mm) == mal) && (ms == 0);
    mbuz = (mst == RING) && (mring % 2 == 0) && mtone;
    mtone = mtone ^ tick_tone;
    nst = mst; nring = mring; nsnz = msnz;
    if (al_toggle) nst = (mst == OFF) ? ARM : OFF;
    else if (mst == ARM && match) begin nst = RING; nring = 0; end
    else if (mst == RING && snooze) begin nst = SNZ; nsnz = SN; end
    else if (mst == RING && tick_1hz) begin
      if (mring + 1 == RT) nst = ARM;
      else nring = mring + 1;
    end else if (mst == SNZ && tick_1hz) begin
      if (msnz == 1) begin nst = RING; nring = 0; end
      else nsnz = msnz - 1;
    end
    if (al_adj) mal = (mal + STEP) % 720;
    ms = ns; mm = nm; mh = nh;
    mst = nst; mring = nring; msnz = nsnz;
  endtask

  task automatic check_all();
    chk("seconds", seconds, ms);
    chk("minutes", minutes, mm);
    chk("hours", hours, mh);
    chk("al_minutes", al_minutes, mal % 60);
    chk("al_hours", al_hours, mal / 60);
    chk("al_on", al_on, int'(mst != OFF));
    chk("ringing", ringing, int'(mst == RING));
    chk("buzzer_out", buzzer_out, int'(mbuz));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    tick_1hz = 0; tick_tone = 0; sec_adj = 0; min_adj = 0;
    hrs_adj = 0; al_adj = 0; al_toggle = 0; snooze = 0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    if (mst != OFF) begin al_toggle = 1; step(); end
    repeat ((s - ms + 60) % 60) begin sec_adj = 1; step(); end
    repeat ((m - mm + 60) % 60) begin min_adj = 1; step(); end
    repeat ((h - mh + 12) % 12) begin hrs_adj = 1; step(); end
  endtask

  task automatic set_alarm(input int t);
    repeat (((t - mal + 720) % 720) / STEP) begin al_adj = 1; step(); end
  endtask

  task automatic arm();
    if (mst == OFF) begin al_toggle = 1; step(); end
  endtask

  // Alarm 01:10, time 01:09:57, armed; three ticks reach the match second.
  task automatic ring_up();
    set_time(1, 9, 57);
    set_alarm(70);
    arm();
    repeat (3) begin tick_1hz = 1; step(); end
    step();
  endtask

  initial begin
    int cnt;
    int tgt;
    vecs[0] = '{1,0,0,0,0,0, 1,0,0, 0,0, 0};
    vecs[1] = '{1,0,0,0,0,1, 2,0,0, 0,0, 0};
    vecs[2] = '{0,1,0,0,0,0, 2,1,0, 0,0, 0};
    vecs[3] = '{0,0,1,0,0,0, 2,1,1, 0,0, 0};
    vecs[4] = '{0,0,0,1,0,0, 2,1,1, 10,0, 0};
    vecs[5] = '{0,1,0,1,0,0, 2,2,1, 20,0, 0};
    vecs[6] = '{0,0,0,0,1,0, 2,2,1, 20,0, 1};
    vecs[7] = '{0,0,0,0,1,0, 2,2,1, 20,0, 0};
    vecs[8] = '{1,1,1,0,0,0, 3,3,2, 20,0, 0};

    reset = 1;
    step();
    tick_1hz = 1; al_toggle = 1; al_adj = 1;
    step();
    chk("rst_seconds", seconds, 0);
    chk("rst_al_minutes", al_minutes, 0);
    chk("rst_al_on", al_on, 0);
    chk("rst_buzzer", buzzer_out, 0);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      sec_adj = vecs[i].sa; min_adj = vecs[i].ma; hrs_adj = vecs[i].ha;
      al_adj = vecs[i].aa; al_toggle = vecs[i].at; tick_1hz = vecs[i].tk;
      step();
      chk("vec_seconds", seconds, vecs[i].es);
      chk("vec_minutes", minutes, vecs[i].em);
      chk("vec_hours", hours, vecs[i].eh);
      chk("vec_al_minutes", al_minutes, vecs[i].eam);
      chk("vec_al_hours", al_hours, vecs[i].eah);
      chk("vec_al_on", al_on, int'(vecs[i].eon));
    end

    set_time(11, 59, 59);
    tick_1hz = 1; step();
    chk("wrap_sec", seconds, 0); chk("wrap_min", minutes, 0); chk("wrap_hrs", hours, 0);
    set_time(11, 59, 59);
    tick_1hz = 1; min_adj = 1; step();
    chk("wrap2_sec", seconds, 0); chk("wrap2_min", minutes, 0); chk("wrap2_hrs", hours, 0);

    set_time(2, 30, 59);
    sec_adj = 1; step();
    chk("secadj_wrap_sec", seconds, 0); chk("secadj_wrap_min", minutes, 30);
    set_time(2, 59, 10);
    min_adj = 1; step();
    chk("minadj_wrap_min", minutes, 0); chk("minadj_wrap_hrs", hours, 2);

    set_alarm(11 * 60 + 50);
    al_adj = 1; step();
    chk("al_wrap_min", al_minutes, 0); chk("al_wrap_hrs", al_hours, 0);
    set_alarm(3 * 60 + 20);
    al_adj = 1; step();
    chk("al_step_min", al_minutes, 30); chk("al_step_hrs", al_hours, 3);

    set_time(1, 9, 57);
    set_alarm(70);
    arm();
    repeat (3) begin tick_1hz = 1; step(); end
    chk("match_sec", seconds, 0); chk("match_min", minutes, 10);
    chk("match_not_yet", ringing, 0);
    step();
    chk("ring_start", ringing, 1);
    cnt = 0;
    repeat (6) begin tick_tone = 1; step(); cnt += int'(buzzer_out); end
    chk("buzz_on_sec_highs", cnt, 3);
    tick_1hz = 1; tick_tone = 1; step();
    tick_tone = 1; step();
    cnt = 0;
    repeat (6) begin tick_tone = 1; step(); cnt += int'(buzzer_out); end
    chk("buzz_off_sec_highs", cnt, 0);

    snooze = 1; step();
    chk("snooze_ringing", ringing, 0); chk("snooze_al_on", al_on, 1);
    repeat (SN - 1) begin tick_1hz = 1; tick_tone = 1; step(); end
    chk("snooze_hold", ringing, 0);
    tick_1hz = 1; step();
    chk("snooze_rering", ringing, 1);
    repeat (RT - 1) begin tick_1hz = 1; tick_tone = 1; step(); end
    chk("timeout_hold", ringing, 1);
    tick_1hz = 1; tick_tone = 1; step();
    chk("timeout_ringing", ringing, 0); chk("timeout_al_on", al_on, 1);
    tick_tone = 1; step();
    chk("timeout_buzzer", buzzer_out, 0);

    ring_up();
    chk("ring2_start", ringing, 1);
    al_toggle = 1; snooze = 1; step();
    chk("toggle_beats_snooze_on", al_on, 0); chk("toggle_beats_snooze_ring", ringing, 0);

    ring_up();
    chk("ring3_start", ringing, 1);
    tick_tone = 1; step();
    reset = 1; step(); reset = 0;
    chk("midring_rst_sec", seconds, 0); chk("midring_rst_min", minutes, 0);
    chk("midring_rst_hrs", hours, 0); chk("midring_rst_almin", al_minutes, 0);
    chk("midring_rst_alhrs", al_hours, 0); chk("midring_rst_alon", al_on, 0);
    chk("midring_rst_ring", ringing, 0); chk("midring_rst_buzz", buzzer_out, 0);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 5)) begin al_adj = 1; step(); end
      tgt = (mal + 719) % 720;
      set_time(tgt / 60, tgt % 60, 57);
      arm();
      for (int c = 0; c < 200; c++) begin
        tick_1hz  = ($urandom % 2) == 0;
        tick_tone = ($urandom % 2) == 0;
        sec_adj   = ($urandom % 50) == 0;
        min_adj   = ($urandom % 50) == 0;
        hrs_adj   = ($urandom % 60) == 0;
        al_adj    = ($urandom % 100) == 0;
        al_toggle = ($urandom % 80) == 0;
        snooze    = ($urandom % 25) == 0;
        reset     = ($urandom % 400) == 0;
        step();
      end
      reset = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
